// File: rtl/pusch_bf_pkg.sv
// Shared types and arithmetic helpers for the beamforming datapath.
package pusch_bf_pkg;

  localparam int unsigned CW_W     = 32;
  localparam int unsigned HALF_W   = CW_W / 2;
  localparam int unsigned CW_RE_MSB = CW_W - 1;
  localparam int unsigned CW_IM_MSB = HALF_W - 1;
  localparam int unsigned PP_W     = 2 * HALF_W;
  // Sum of two full products needs 33 bits; one spare bit keeps the rounding add safe.
  localparam int unsigned PROD_W   = PP_W + 2;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cplx_t;

  // Round half up at bit 'shift', then clamp to a signed 'ow'-bit range (result sign-extended).
  function automatic logic signed [PROD_W-1:0] round_sat(
    input logic signed [PROD_W-1:0] val,
    input int unsigned              shift,
    input int unsigned              ow
  );
    logic signed [PROD_W-1:0] rnd;
    logic signed [PROD_W-1:0] r;
    logic signed [PROD_W-1:0] hi;
    logic signed [PROD_W-1:0] lo;
    logic signed [PROD_W-1:0] res;
    rnd = PROD_W'(1) << (shift - 1);
    r   = val + rnd;
    r   = r >>> shift;
    hi  = (PROD_W'(1) << (ow - 1)) - PROD_W'(1);
    lo  = ~hi;
    if (r > hi) begin
      res = hi;
    end else if (r < lo) begin
      res = lo;
    end else begin
      res = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmpy_round_sat.sv
// One antenna lane: registered complex multiply followed by round/saturate.
module cmpy_round_sat
  import pusch_bf_pkg::*;
#(
  parameter int unsigned OW    = 16,
  parameter int unsigned SHIFT = 15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [CW_W-1:0] a_i,
  input  logic [CW_W-1:0] b_i,
  output logic [2*OW-1:0] y_o
);

  cplx_t                    a_q, b_q;
  logic signed [PP_W-1:0]   pp_rr_d, pp_ii_d, pp_ri_d, pp_ir_d;
  logic signed [PP_W-1:0]   pp_rr_q, pp_ii_q, pp_ri_q, pp_ir_q;
  logic signed [PROD_W-1:0] re_sum_d, im_sum_d;
  logic signed [PROD_W-1:0] re_sum_q, im_sum_q;
  logic signed [PROD_W-1:0] re_rs, im_rs;
  logic [2*OW-1:0]          y_d, y_q;

  // Partial products, sums and the rounded/saturated result.
  always_comb begin
    pp_rr_d  = PP_W'($signed(a_q.re)) * PP_W'($signed(b_q.re));
    pp_ii_d  = PP_W'($signed(a_q.im)) * PP_W'($signed(b_q.im));
    pp_ri_d  = PP_W'($signed(a_q.re)) * PP_W'($signed(b_q.im));
    pp_ir_d  = PP_W'($signed(a_q.im)) * PP_W'($signed(b_q.re));
    re_sum_d = PROD_W'(pp_rr_q) - PROD_W'(pp_ii_q);
    im_sum_d = PROD_W'(pp_ri_q) + PROD_W'(pp_ir_q);
    re_rs    = round_sat(re_sum_q, SHIFT, OW);
    im_rs    = round_sat(im_sum_q, SHIFT, OW);
    y_d      = {re_rs[OW-1:0], im_rs[OW-1:0]};
  end

  // Four register stages: operands, products, sums, output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      pp_rr_q  <= '0;
      pp_ii_q  <= '0;
      pp_ri_q  <= '0;
      pp_ir_q  <= '0;
      re_sum_q <= '0;
      im_sum_q <= '0;
      y_q      <= '0;
    end else begin
      a_q      <= cplx_t'(a_i);
      b_q      <= cplx_t'(b_i);
      pp_rr_q  <= pp_rr_d;
      pp_ii_q  <= pp_ii_d;
      pp_ri_q  <= pp_ri_d;
      pp_ir_q  <= pp_ir_d;
      re_sum_q <= re_sum_d;
      im_sum_q <= im_sum_d;
      y_q      <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/ants_expand.sv
// Beam-to-antenna expander with a double-buffered code-word bank swapped on symbol start.
module ants_expand
  import pusch_bf_pkg::*;
#(
  parameter int unsigned ANT   = 32,
  parameter int unsigned IW    = 32,
  parameter int unsigned OW    = 16,
  parameter int unsigned SHIFT = 15,
  parameter int unsigned AW    = $clog2(ANT)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [IW-1:0]       i_beam_data,
  input  logic                i_rvalid,
  input  logic                i_sop,
  input  logic                i_cw_wr,
  input  logic [AW-1:0]       i_cw_addr,
  input  logic [IW-1:0]       i_cw_data,
  input  logic                i_cw_commit,
  output logic [ANT*2*OW-1:0] o_ants_data,
  output logic                o_tvalid,
  output logic                o_sop,
  output logic                o_cw_pending,
  output logic                o_swap,
  output logic [7:0]          o_swap_cnt
);

  localparam int unsigned LAT = 4;

  logic [IW-1:0]  shadow_q [ANT];
  logic [IW-1:0]  shadow_d [ANT];
  logic [IW-1:0]  active_q [ANT];
  logic [IW-1:0]  active_d [ANT];
  logic [IW-1:0]  w_c      [ANT];
  logic           pending_q, pending_d;
  logic           swap_q, swap_c;
  logic [7:0]     swap_cnt_q, swap_cnt_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT-1:0] sop_q, sop_d;

  // Bank update, commit/swap control and the valid/SOP delay line.
  always_comb begin
    swap_c     = pending_q && i_rvalid && i_sop;
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q;
    swap_cnt_d = swap_cnt_q;
    // Active takes the pre-write shadow; a same-cycle write only reaches the shadow.
    if (swap_c) begin
      active_d   = shadow_q;
      pending_d  = 1'b0;
      swap_cnt_d = swap_cnt_q + 8'd1;
    end
    if (i_cw_commit) begin
      pending_d = 1'b1;
    end
    if (i_cw_wr) begin
      shadow_d[i_cw_addr] = i_cw_data;
    end
    // The swap-cycle sample must already see the incoming weights.
    for (int k = 0; k < ANT; k++) begin
      w_c[k] = swap_c ? shadow_q[k] : active_q[k];
    end
    vld_d = {vld_q[LAT-2:0], i_rvalid};
    sop_d = {sop_q[LAT-2:0], i_rvalid & i_sop};
  end

  // Control and bank registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < ANT; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      pending_q  <= 1'b0;
      swap_q     <= 1'b0;
      swap_cnt_q <= '0;
      vld_q      <= '0;
      sop_q      <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      swap_q     <= swap_c;
      swap_cnt_q <= swap_cnt_d;
      vld_q      <= vld_d;
      sop_q      <= sop_d;
    end
  end

  // One multiply/round lane per antenna.
  for (genvar k = 0; k < ANT; k++) begin : g_ant
    cmpy_round_sat #(
      .OW    (OW),
      .SHIFT (SHIFT)
    ) u_cmpy (
      .clk_i (i_clk),
      .rst_i (i_reset),
      .a_i   (i_beam_data),
      .b_i   (w_c[k]),
      .y_o   (o_ants_data[2*OW*k +: 2*OW])
    );
  end

  assign o_tvalid     = vld_q[LAT-1];
  assign o_sop        = sop_q[LAT-1];
  assign o_cw_pending = pending_q;
  assign o_swap       = swap_q;
  assign o_swap_cnt   = swap_cnt_q;

endmodule

// File: doc/ants_expand.md
# ants_expand

Beam-to-antenna expander: the transmit-direction counterpart of the antenna combiner. It takes one complex beam sample per cycle and produces one weighted copy per antenna, `out[k] = round_sat(beam × cw[k])`. The per-antenna code words live in a double-buffered register bank. Software loads the shadow bank, and the block promotes it to active only on a symbol boundary, so a symbol is never split across two weight sets. It sits between the beam-domain sample source and the per-antenna IFFT/fronthaul packers.

## Interface
- `ANT`, 32: number of antennas; power of two, 2..64.
- `IW`, 32: complex input/code-word width; `[31:16]` = re, `[15:0]` = im, signed.
- `OW`, 16: per-component output width.
- `SHIFT`, 15: right shift applied to the full-precision product before rounding; 1..31.
- `AW`, `$clog2(ANT)`: code-word address width (derived).

Ports:
- `i_clk`, in, 1: the one clock.
- `i_reset`, in, 1: reset, asynchronous and active-high.
- `i_beam_data`, in, IW: beam sample.
- `i_rvalid`, in, 1: sample valid.
- `i_sop`, in, 1: first sample of a symbol; qualified by `i_rvalid`.
- `i_cw_wr`, in, 1: write strobe to the shadow bank.
- `i_cw_addr`, in, AW: antenna index.
- `i_cw_data`, in, IW: complex code word.
- `i_cw_commit`, in, 1: marks shadow bank as ready.
- `o_ants_data`, out, ANT*2*OW: antenna k in `[2*OW*k +: 2*OW]` as {re, im}.
- `o_tvalid`, out, 1: output valid.
- `o_sop`, out, 1: delayed `i_sop`.
- `o_cw_pending`, out, 1: shadow committed, not yet active.
- `o_swap`, out, 1: one-cycle pulse on the cycle the active bank is loaded.
- `o_swap_cnt`, out, 8: number of swaps, wraps at 255→0.

## Operation
- **Shadow writes.** On `i_cw_wr`, `shadow[i_cw_addr] <= i_cw_data`. Writes are always accepted, including while pending.
- **Commit.**
  - `i_cw_commit` sets `pending`.
  - Repeated commits while pending have no extra effect.
- **Swap condition.** A swap occurs on any cycle with `pending && i_rvalid && i_sop`.
- **Swap action.**
  - `active <= shadow` as a copy. The shadow keeps its contents.
  - `pending` clears, unless `i_cw_commit` is high in the same cycle, in which case it stays 1.
  - `o_swap` pulses high for that cycle.
  - `o_swap_cnt` increments.
- **Which weights a sample uses.**
  - The sample presented on the swap cycle already uses the new weights.
  - A write on the swap cycle lands in the shadow only. The active bank receives the pre-write shadow value.
- **Commit and SOP in the same cycle with pending=0.** No swap happens; `pending` becomes 1; the next SOP swaps.
- **Arithmetic, per antenna** (a = beam, b = cw[k]):
  - re = a.re·b.re − a.im·b.im
  - im = a.re·b.im + a.im·b.re
  - Products are kept at full 33-bit signed precision.
  - Add 2^(SHIFT−1), then arithmetic shift right by SHIFT (round half up).
  - Saturate to the signed OW range: [−2^(OW−1), 2^(OW−1)−1].
- **Flow control.** No backpressure; the pipeline is free-running. Invalid samples flow through with `o_tvalid`=0, and `o_ants_data` is don't-care on those cycles.

## Timing
- **Latency.** 4 cycles: `i_rvalid`/`i_sop` at cycle T produce `o_tvalid`/`o_sop` at T+4.
  - Stage 1: input and weight register.
  - Stage 2: partial products.
  - Stage 3: sum.
  - Stage 4: round/saturate register.
- **Throughput.** One sample per cycle, sustained indefinitely.
- **Weight selection.** The active weight is sampled in stage 1 alongside the data, so a swap affects exactly the samples from the swap cycle onward.
- **`o_cw_pending`** is registered. It rises the cycle after commit and falls the cycle after the swap.
- **Reset values.**
  - Both banks all zero.
  - `pending`=0.
  - `o_ants_data`=0, `o_tvalid`=0, `o_sop`=0, `o_swap`=0, `o_swap_cnt`=0, `o_cw_pending`=0.
  - All pipeline valid bits are cleared, so a reset mid-stream drops any in-flight samples.
- **First data after reset with no commit:** output is zeros, with `o_tvalid` asserted normally.

## Structure
- **Shared package `pusch_bf_pkg`:**
  - `cplx_t` (packed re/im of IW/2 each).
  - `CW_RE_MSB` / `CW_IM_MSB` field constants.
  - Function `round_sat(val, SHIFT, OW)`.
- **Sub-module `cmpy_round_sat`** (one per antenna, generate loop):
  - Two-stage complex multiply plus round/saturate.
  - 4-cycle pipeline, excluding the data-valid path.
- **Top level** holds the bank registers, the commit/swap control and the valid/SOP delay line.

## Test plan
- **Basic gain.** Write cw[0]=0x4000_0000, commit, then send SOP with beam=0x2000_1000. Required: ant0 = {0x1000, 0x0800} at T+4; all other antennas 0.
- **Saturation.** beam=0x8000_8000, cw[k]=0x8000_0000. Required: re=0x7FFF, im=0x7FFF (positive clip); with beam=0x7FFF_0000 and cw=0x8000_0000, re=0x8001, im=0x0000.
- **Rounding.** beam=0x0001_0000, cw=0x4000_0000. Required: re=1 (16384 rounds up), im=0.
- **Swap on boundary.** Commit weights B mid-symbol (weights A active); send 3 non-SOP samples, then a SOP. Required: the 3 samples use A, the SOP sample uses B, `o_swap` pulses once, `o_swap_cnt`=1.
- **Simultaneous events.** Commit and SOP in the same cycle with pending=0 → no swap, pending=1. Commit on the swap cycle → swap occurs and pending stays 1. Write on the swap cycle → the active bank holds the pre-write value.
- **Reset mid-stream.** Assert `i_reset` during continuous valid input. Required: all outputs 0 the same cycle; the first `o_tvalid` appears 4 cycles after input resumes; outputs are zero until a new commit and swap.
